wca_rbus_master: RTL
====================

# wca_rbus_master

Two-port register-bus master that sequences byte-serial read and write transactions on the 12-bit Wca register bus, including 1–4 byte dword accesses. It round-robin arbitrates between two internal requesters, for example the host command decoder and the DSP configuration engine. It generates the address, enable, strobe and bus-clock lines on its own system clock, and owns one driver of the tri-state data bus. It ensures each slave's byte-select counter is cleared between transactions.

## Interface
- IDLE_ADDR, 8'hFF: address driven while idle or releasing; must not match any slave address.
- clock  in  1  system clock; all outputs are registered on its rising edge.
- reset  in  1  asynchronous, active-high.
- req0 / req1  in  1  request level; held until the matching done pulse.
- we0 / we1  in  1  1 = write, 0 = read.
- addr0 / addr1  in  8  register address.
- len0 / len1  in  2  byte count minus 1 (0 → 1 byte … 3 → 4 bytes).
- wdata0 / wdata1  in  32  write data, LSB byte first.
- grant0 / grant1  out  1  high for the whole transaction of that port.
- done0 / done1  out  1  one-cycle completion pulse.
- rdata0 / rdata1  out  32  read data; unread upper bytes are 0; held until that port's next read completes.
- busy  out  1  high when the FSM is not in IDLE.
- rbusCtrl  out  12  {addr[7:0], readEnable, writeEnable, dataStrobe, clkbus}.
- rbusData  inout  8  driven only during write byte phases, Z otherwise.

## Operation
- FSM states: IDLE → SETUP → STRB → CLKH, then either SETUP for the next byte or REL → RELCLK → IDLE.
- IDLE
  - Drives rbusCtrl = {IDLE_ADDR, 4'b0000}.
  - If any req is high, the arbiter selects a port.
  - The FSM latches we, addr, len and wdata from that port, sets grant, clears byte index k and enters SETUP.
- SETUP: addr = latched address; readEnable = ~we, writeEnable = we, dataStrobe = 0, clkbus = 0. For writes, rbusData = wdata byte k.
- STRB: same as SETUP plus dataStrobe = 1. For reads, rbusData is captured into rdata byte k at the end of this cycle.
- CLKH: same as STRB plus clkbus = 1. The slave advances its select on this edge.
  - If k == len, go to REL.
  - Otherwise k++ and go to SETUP.
- REL: addr = IDLE_ADDR, enables and strobe = 0, clkbus = 0; rbusData is Z.
- RELCLK: as REL with clkbus = 1, which clears every slave's select counter.
  - Then IDLE, with done and the updated rdata of the granted port visible in that IDLE cycle.
  - grant drops in the same cycle.
- Arbitration
  - Round-robin: on simultaneous requests, the port not served last wins.
  - After reset, port 0 has priority.
  - Requests are sampled only in IDLE. A new grant may be issued in the same IDLE cycle that done is high.
- Byte order: byte k is data[8k+7:8k], starting from bits 7:0.
- A req that drops mid-transaction is ignored; the transaction completes and done still pulses.
- Reset (asynchronous, at any time) forces:
  - state IDLE;
  - rbusCtrl = {IDLE_ADDR, 4'b0};
  - rbusData Z;
  - grant, done and busy = 0;
  - rdata0/1 = 0;
  - round-robin pointer = port 0.
- An aborted transaction produces no done.

## Timing
- Accepting cycle (IDLE with req) → first SETUP: 1 cycle.
- Each byte: 3 cycles (SETUP, STRB, CLKH).
- Release: 2 cycles.
- From the acceptance edge to done high: 3·(len+1) + 3 cycles, i.e. 6 cycles for 1 byte and 15 cycles for 4 bytes.
- Back-to-back transactions: the next SETUP follows done by one cycle.
- clkbus is never high in two consecutive cycles. Address and enables are stable for at least one cycle before and during every clkbus high.

## Structure
- Shared package wca_rbus_pkg holds:
  - rbusCtrl bit indices: ADDR_MSB = 11, ADDR_LSB = 4, RD = 3, WR = 2, STB = 1, CLK = 0;
  - the FSM state enum;
  - the IDLE_ADDR default.
- Sub-module wca_rr_arb2: a 2-input round-robin arbiter with a last-served pointer and an update strobe.

## Test plan
- Read: port 0 reads 4 bytes (len = 3) from a slave at 0x10 holding 0xDEADBEEF.
  - rdata0 = 0xDEADBEEF, done0 at cycle 15.
  - Four clkbus pulses at addr 0x10, then one at 0xFF.
- Write: port 1 writes 1 byte (len = 0), 0x000000A5, to 0x22.
  - rbusData = 0xA5 only during SETUP, STRB and CLKH; writeEnable high; done1 at cycle 6.
  - rdata1 stays unchanged.
- Simultaneous requests: req0 and req1 rise together after reset.
  - Port 0 is served first, then port 1, with back-to-back grants.
  - Repeating both requests gives port 0 again only after port 1 (alternation).
- Select clear: two consecutive 2-byte reads of the same slave return the same low bytes, proving the RELCLK pulse clears select.
- Reset mid-read: assert reset during the STRB of byte 1.
  - All outputs reach their reset values immediately; no done.
  - A subsequent read returns correct data.
- Dropped request: req0 deasserts during byte 0 → the transaction still completes and done0 pulses once.

Source files
------------

// File: rtl/wca_rbus_pkg.sv
// Shared definitions for the Wca register-bus master: rbusCtrl bit layout,
// FSM state encoding and the idle bus address.
package wca_rbus_pkg;

    localparam int unsigned ADDR_MSB = 11;
    localparam int unsigned ADDR_LSB = 4;
    localparam int unsigned RD       = 3;
    localparam int unsigned WR       = 2;
    localparam int unsigned STB      = 1;
    localparam int unsigned CLK      = 0;

    localparam logic [7:0] IDLE_ADDR = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STRB,
        ST_CLKH,
        ST_REL,
        ST_RELCLK
    } state_t;

    function automatic logic [11:0] pack_ctrl(input logic [7:0] addr, input logic rd,
                                              input logic wr, input logic stb, input logic clk);
        logic [11:0] c;
        c                    = '0;
        c[ADDR_MSB:ADDR_LSB] = addr;
        c[RD]                = rd;
        c[WR]                = wr;
        c[STB]               = stb;
        c[CLK]               = clk;
        return c;
    endfunction

endpackage

// File: rtl/wca_rr_arb2.sv
// Two-input round-robin arbiter; the pointer remembers the last port served
// and only moves when the owner accepts a grant via update.
module wca_rr_arb2 (
    input  logic clock,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic update,
    output logic valid,
    output logic sel
);

    logic last_q;
    logic last_d;

    always_comb begin
        valid = req0 | req1;
        if (req0 && req1) begin
            sel = ~last_q;
        end else begin
            sel = req1;
        end
        last_d = update ? sel : last_q;
    end

    // Pointer starts at "port 1 served last" so port 0 wins the first tie.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/wca_rbus_master.sv
// Two-port byte-serial master for the 12-bit Wca register bus; sequences
// 1-4 byte reads/writes and pulses clkbus at the idle address to reset slave selects.
module wca_rbus_master
    import wca_rbus_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [7:0]  addr0,
    input  logic [7:0]  addr1,
    input  logic [1:0]  len0,
    input  logic [1:0]  len1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        grant0,
    output logic        grant1,
    output logic        done0,
    output logic        done1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        busy,
    output logic [11:0] rbusCtrl,
    inout  wire  [7:0]  rbusData
);

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [7:0]  addr_q, addr_d;
    logic [1:0]  len_q, len_d;
    logic [31:0] wdata_q, wdata_d;
    logic        port_q, port_d;
    logic [1:0]  k_q, k_d;
    logic [31:0] rbuf_q, rbuf_d;
    logic        grant0_q, grant0_d, grant1_q, grant1_d;
    logic        done0_q, done0_d, done1_q, done1_d;
    logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic [11:0] ctrl_q, ctrl_d;
    logic        oe_q, oe_d;
    logic [7:0]  dout_q, dout_d;

    logic        arb_valid;
    logic        arb_sel;
    logic        arb_update;

    // A port's request is ignored while its own done is showing, so a
    // requester that drops req on seeing done is not served twice.
    wca_rr_arb2 u_arb (
        .clock  (clock),
        .reset  (reset),
        .req0   (req0 & ~done0_q),
        .req1   (req1 & ~done1_q),
        .update (arb_update),
        .valid  (arb_valid),
        .sel    (arb_sel)
    );

    assign arb_update = arb_valid && (state_q == ST_IDLE);

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        addr_d   = addr_q;
        len_d    = len_q;
        wdata_d  = wdata_q;
        port_d   = port_q;
        k_d      = k_q;
        rbuf_d   = rbuf_q;
        grant0_d = grant0_q;
        grant1_d = grant1_q;
        done0_d  = 1'b0;
        done1_d  = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;

        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    port_d   = arb_sel;
                    we_d     = arb_sel ? we1    : we0;
                    addr_d   = arb_sel ? addr1  : addr0;
                    len_d    = arb_sel ? len1   : len0;
                    wdata_d  = arb_sel ? wdata1 : wdata0;
                    k_d      = 2'd0;
                    rbuf_d   = '0;
                    grant0_d = ~arb_sel;
                    grant1_d = arb_sel;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: state_d = ST_STRB;
            ST_STRB: begin
                if (!we_q) begin
                    rbuf_d[{k_q, 3'b000} +: 8] = rbusData;
                end
                state_d = ST_CLKH;
            end
            ST_CLKH: begin
                if (k_q == len_q) begin
                    state_d = ST_REL;
                end else begin
                    k_d     = k_q + 2'd1;
                    state_d = ST_SETUP;
                end
            end
            ST_REL: state_d = ST_RELCLK;
            ST_RELCLK: begin
                state_d  = ST_IDLE;
                grant0_d = 1'b0;
                grant1_d = 1'b0;
                if (port_q) begin
                    done1_d = 1'b1;
                    if (!we_q) rdata1_d = rbuf_q;
                end else begin
                    done0_d = 1'b1;
                    if (!we_q) rdata0_d = rbuf_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Bus outputs are decoded from the next state so they are registered
        // alongside it and always match the current state.
        ctrl_d = pack_ctrl(IDLE_ADDR, 1'b0, 1'b0, 1'b0, 1'b0);
        oe_d   = 1'b0;
        dout_d = '0;
        case (state_d)
            ST_SETUP, ST_STRB, ST_CLKH: begin
                ctrl_d = pack_ctrl(addr_d, ~we_d, we_d, state_d != ST_SETUP, state_d == ST_CLKH);
                oe_d   = we_d;
                if (we_d) dout_d = wdata_d[{k_d, 3'b000} +: 8];
            end
            ST_RELCLK: ctrl_d = pack_ctrl(IDLE_ADDR, 1'b0, 1'b0, 1'b0, 1'b1);
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            we_q     <= 1'b0;
            addr_q   <= IDLE_ADDR;
            len_q    <= '0;
            wdata_q  <= '0;
            port_q   <= 1'b0;
            k_q      <= '0;
            rbuf_q   <= '0;
            grant0_q <= 1'b0;
            grant1_q <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            ctrl_q   <= pack_ctrl(IDLE_ADDR, 1'b0, 1'b0, 1'b0, 1'b0);
            oe_q     <= 1'b0;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            wdata_q  <= wdata_d;
            port_q   <= port_d;
            k_q      <= k_d;
            rbuf_q   <= rbuf_d;
            grant0_q <= grant0_d;
            grant1_q <= grant1_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            ctrl_q   <= ctrl_d;
            oe_q     <= oe_d;
            dout_q   <= dout_d;
        end
    end

    assign grant0   = grant0_q;
    assign grant1   = grant1_q;
    assign done0    = done0_q;
    assign done1    = done1_q;
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;
    assign busy     = (state_q != ST_IDLE);
    assign rbusCtrl = ctrl_q;
    assign rbusData = oe_q ? dout_q : 8'hzz;

endmodule
